// File: rtl/issue_ctrl_if.sv
// Shared decoded-op encoding and the decode/retire bundle between the
// decoder, the issue controller and the execute stage.

package issue_pkg;
   typedef enum logic [4:0] {
      OP_NOP     = 5'd0,
      OP_ALU     = 5'd1,
      OP_LOAD    = 5'd2,
      OP_STORE   = 5'd3,
      OP_BRANCH  = 5'd4,
      OP_JAL     = 5'd5,
      OP_FENCE   = 5'd6,
      OP_FENCEI  = 5'd7,
      OP_SFENCE  = 5'd8,
      OP_ECALL   = 5'd9,
      OP_EBREAK  = 5'd10,
      OP_MRET    = 5'd11,
      OP_SRET    = 5'd12,
      OP_URET    = 5'd13,
      OP_WFI     = 5'd14,
      OP_CSRRW   = 5'd15,
      OP_CSRRS   = 5'd16,
      OP_CSRRC   = 5'd17,
      OP_CSRRWI  = 5'd18,
      OP_CSRRSI  = 5'd19,
      OP_CSRRCI  = 5'd20,
      OP_INVALID = 5'd21
   } op_t;
endpackage

interface issue_ctrl_if #(
   parameter int MAX_INFLIGHT = 3,
   parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) ();
   // decode side
   logic               id_valid;
   issue_pkg::op_t     id_op;
   logic [4:0]         id_raddr1;
   logic [4:0]         id_raddr2;
   logic               id_we;
   logic [4:0]         id_waddr;
   logic               id_ready;
   logic               hazard;
   // pipeline control
   logic               ex_stall;
   logic               flush;
   // retire side
   logic               ret_valid;
   logic               ret_clr;
   logic [4:0]         ret_waddr;
   // status
   logic [CNT_W-1:0]   inflight;
   logic               serial_busy;
   logic               sb_err;

   modport master (
      output id_valid, id_op, id_raddr1, id_raddr2, id_we, id_waddr,
      output ex_stall, flush, ret_valid, ret_clr, ret_waddr,
      input  id_ready, hazard, inflight, serial_busy, sb_err
   );

   modport slave (
      input  id_valid, id_op, id_raddr1, id_raddr2, id_we, id_waddr,
      input  ex_stall, flush, ret_valid, ret_clr, ret_waddr,
      output id_ready, hazard, inflight, serial_busy, sb_err
   );
endinterface

// File: rtl/issue_ctrl.sv
// Issue controller: pending-write scoreboard, in-flight counter and a
// drain/wait sequencer that isolates serializing ops (CSR, fence.i,
// system ops, invalid) from everything older and younger.

module issue_ctrl
   import issue_pkg::*;
#(
   parameter int MAX_INFLIGHT = 3,
   parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic         clk,
   input  logic         rst_n,
   issue_ctrl_if.slave  bus
);

   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_INFLIGHT);
   localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
   localparam logic [CNT_W-1:0] ZERO_CNT = CNT_W'(0);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRAIN = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t             state_r;
   state_t             state_nx_s;
   logic [31:0]        pending_r;
   logic [31:0]        pending_nx_s;
   logic [CNT_W-1:0]   inflight_r;
   logic [CNT_W-1:0]   inflight_nx_s;
   logic               sb_err_r;
   logic               sb_err_nx_s;

   logic               serial_op_s;
   logic               hazard_s;
   logic               base_ready_s;
   logic               ready_s;
   logic               issue_s;
   logic               cnt_zero_s;

   // Ops that must run with an empty pipeline on both sides.
   function automatic logic is_serial(input op_t op);
      logic res;
      case (op)
         OP_FENCEI, OP_SFENCE, OP_ECALL, OP_EBREAK,
         OP_MRET, OP_SRET, OP_URET, OP_WFI,
         OP_CSRRW, OP_CSRRS, OP_CSRRC,
         OP_CSRRWI, OP_CSRRSI, OP_CSRRCI,
         OP_INVALID: res = 1'b1;
         default:    res = 1'b0;
      endcase
      return res;
   endfunction

   // Register x0 is never tracked, so a zero address can never collide.
   function automatic logic pend_hit(input logic [31:0] pend, input logic [4:0] addr);
      return (addr != 5'd0) && pend[addr];
   endfunction

   assign serial_op_s = is_serial(bus.id_op);
   assign cnt_zero_s  = (inflight_r == ZERO_CNT);

   // RAW/WAW check against registered scoreboard only (clears are not bypassed).
   always_comb begin
      hazard_s = 1'b0;
      if (bus.id_valid) begin
         hazard_s = pend_hit(pending_r, bus.id_raddr1)
                  | pend_hit(pending_r, bus.id_raddr2)
                  | (bus.id_we & pend_hit(pending_r, bus.id_waddr));
      end else begin
         hazard_s = 1'b0;
      end
   end

   assign base_ready_s = ~bus.ex_stall & ~bus.flush & ~hazard_s & (inflight_r < MAX_CNT);

   // Serialization sequencer: next state and issue permission.
   always_comb begin
      state_nx_s = state_r;
      ready_s    = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (!serial_op_s) begin
               ready_s = base_ready_s;
            end else if (cnt_zero_s) begin
               ready_s = base_ready_s;
               if (bus.id_valid && base_ready_s) begin
                  state_nx_s = S_WAIT;
               end else begin
                  state_nx_s = S_IDLE;
               end
            end else begin
               ready_s = 1'b0;
               if (bus.id_valid) begin
                  state_nx_s = S_DRAIN;
               end else begin
                  state_nx_s = S_IDLE;
               end
            end
         end
         S_DRAIN: begin
            if (bus.flush) begin
               ready_s    = 1'b0;
               state_nx_s = S_IDLE;
            end else if (cnt_zero_s) begin
               ready_s = base_ready_s;
               if (bus.id_valid && base_ready_s) begin
                  state_nx_s = S_WAIT;
               end else begin
                  state_nx_s = S_DRAIN;
               end
            end else begin
               ready_s    = 1'b0;
               state_nx_s = S_DRAIN;
            end
         end
         S_WAIT: begin
            ready_s = 1'b0;
            // the serial op is the only thing in flight; its retire ends the wait
            if (bus.ret_valid && (inflight_r == ONE_CNT)) begin
               state_nx_s = S_IDLE;
            end else begin
               state_nx_s = S_WAIT;
            end
         end
         default: begin
            ready_s    = 1'b0;
            state_nx_s = S_IDLE;
         end
      endcase
   end

   assign issue_s = bus.id_valid & ready_s;

   // Scoreboard, in-flight counter and error flag next values.
   always_comb begin
      pending_nx_s  = pending_r;
      inflight_nx_s = inflight_r;
      sb_err_nx_s   = sb_err_r;

      // clear first so that a same-cycle set on the same register wins
      if (bus.ret_valid && bus.ret_clr) begin
         pending_nx_s[bus.ret_waddr] = 1'b0;
      end else begin
         pending_nx_s = pending_nx_s;
      end
      if (issue_s && bus.id_we && (bus.id_waddr != 5'd0)) begin
         pending_nx_s[bus.id_waddr] = 1'b1;
      end else begin
         pending_nx_s = pending_nx_s;
      end
      pending_nx_s[0] = 1'b0;

      case ({issue_s, bus.ret_valid})
         2'b10:   inflight_nx_s = inflight_r + ONE_CNT;
         2'b01: begin
            if (cnt_zero_s) begin
               inflight_nx_s = ZERO_CNT;
            end else begin
               inflight_nx_s = inflight_r - ONE_CNT;
            end
         end
         default: inflight_nx_s = inflight_r;
      endcase

      if (bus.ret_valid && cnt_zero_s) begin
         sb_err_nx_s = 1'b1;
      end else begin
         sb_err_nx_s = sb_err_r;
      end
   end

   // State registers; reset discards every in-flight record immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= S_IDLE;
         pending_r  <= 32'd0;
         inflight_r <= ZERO_CNT;
         sb_err_r   <= 1'b0;
      end else begin
         state_r    <= state_nx_s;
         pending_r  <= pending_nx_s;
         inflight_r <= inflight_nx_s;
         sb_err_r   <= sb_err_nx_s;
      end
   end

   // handshake outputs are forced low while reset is held
   assign bus.id_ready    = rst_n & ready_s;
   assign bus.hazard      = rst_n & hazard_s;
   assign bus.inflight    = inflight_r;
   assign bus.serial_busy = (state_r != S_IDLE);
   assign bus.sb_err      = sb_err_r;

endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: directed scenarios plus randomized traffic, all
// checked each cycle against an in-order queue model of the pipeline.

module tb_issue_ctrl;
   import issue_pkg::*;

   localparam int MAXI = 3;
   localparam int CW   = $clog2(MAXI + 1);

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   issue_ctrl_if #(.MAX_INFLIGHT(MAXI)) bus ();
   issue_ctrl #(.MAX_INFLIGHT(MAXI)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int total = 0;
   int bad   = 0;

   // model: queue of issued-but-not-retired instructions, oldest first
   typedef struct {
      bit         ser;
      bit         we;
      logic [4:0] wa;
   } ent_t;
   ent_t q[$];
   bit   pend[32];
   int   cnt;
   bit   drain;
   bit   err;
   bit   exp_rdy, exp_haz, exp_busy;
   bit   chk_en = 1'b0;

   task automatic cmp(input string nm, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
      end
   endtask

   function automatic bit serial(input op_t op);
      case (op)
         OP_FENCEI, OP_SFENCE, OP_ECALL, OP_EBREAK, OP_MRET, OP_SRET, OP_URET,
         OP_WFI, OP_CSRRW, OP_CSRRS, OP_CSRRC, OP_CSRRWI, OP_CSRRSI, OP_CSRRCI,
         OP_INVALID: return 1'b1;
         default:    return 1'b0;
      endcase
   endfunction

   // a serializing instruction is somewhere in the pipe
   function automatic bit ser_in_flight();
      foreach (q[i]) if (q[i].ser) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit busy_reg(input logic [4:0] a);
      return (a != 5'd0) && pend[a];
   endfunction

   task automatic model_reset();
      q.delete();
      foreach (pend[i]) pend[i] = 1'b0;
      cnt = 0; drain = 1'b0; err = 1'b0;
   endtask

   task automatic calc();
      bit base;
      exp_haz = bus.id_valid && (busy_reg(bus.id_raddr1) || busy_reg(bus.id_raddr2) ||
                                 (bus.id_we && busy_reg(bus.id_waddr)));
      base = !bus.ex_stall && !bus.flush && !exp_haz && (cnt < MAXI);
      if (ser_in_flight())          exp_rdy = 1'b0;
      else if (drain)               exp_rdy = (cnt == 0) && base;
      else if (serial(bus.id_op))   exp_rdy = (cnt == 0) && base;
      else                          exp_rdy = base;
      exp_busy = drain || ser_in_flight();
   endtask

   task automatic update();
      bit iss, push_ser;
      iss = bus.id_valid && exp_rdy;
      push_ser = 1'b0;
      if (!ser_in_flight()) begin
         if (drain) begin
            if (bus.flush) drain = 1'b0;
            else if (iss) begin push_ser = 1'b1; drain = 1'b0; end
         end else if (bus.id_valid && serial(bus.id_op)) begin
            if (cnt != 0) drain = 1'b1;
            else if (iss) push_ser = 1'b1;
         end
      end
      if (bus.ret_valid) begin
         if (cnt == 0) err = 1'b1;
         else void'(q.pop_front());
      end
      if (bus.ret_valid && bus.ret_clr) pend[bus.ret_waddr] = 1'b0;
      if (iss && bus.id_we && bus.id_waddr != 5'd0) pend[bus.id_waddr] = 1'b1;
      if (iss && !bus.ret_valid) cnt++;
      else if (!iss && bus.ret_valid && cnt > 0) cnt--;
      if (iss) q.push_back('{push_ser, bus.id_we, bus.id_waddr});
   endtask

   task automatic drive(input bit v, input op_t op, input logic [4:0] r1, r2,
                        input bit we, input logic [4:0] wa, input bit st, fl, rv, rc,
                        input logic [4:0] rw);
      bus.id_valid = v;  bus.id_op = op; bus.id_raddr1 = r1; bus.id_raddr2 = r2;
      bus.id_we = we;    bus.id_waddr = wa; bus.ex_stall = st; bus.flush = fl;
      bus.ret_valid = rv; bus.ret_clr = rc; bus.ret_waddr = rw;
      calc();
   endtask

   task automatic step();
      @(posedge clk);
      update();
      #1;
   endtask

   task automatic retire_front();
      ent_t e;
      e = q[0];
      drive(1'b0, OP_NOP, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1,
            e.we && (e.wa != 5'd0), e.wa);
      step();
   endtask

   task automatic drain_all();
      for (int k = 0; k < 8 && q.size() > 0; k++) retire_front();
   endtask

   // every-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         cmp("id_ready", int'(bus.id_ready), int'(exp_rdy));
         cmp("hazard", int'(bus.hazard), int'(exp_haz));
         cmp("inflight", int'(bus.inflight), cnt);
         cmp("serial_busy", int'(bus.serial_busy), int'(exp_busy));
         cmp("sb_err", int'(bus.sb_err), int'(err));
      end
   end

   initial begin
      bit v, st, fl, rv, rc, we;
      op_t op;
      logic [4:0] r1, r2, wa, rw;
      ent_t e;

      model_reset();
      rst_n = 1'b0;
      drive(1'b1, OP_ALU, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      #2;
      cmp("rst_ready", int'(bus.id_ready), 0);
      cmp("rst_inflight", int'(bus.inflight), 0);
      cmp("rst_busy", int'(bus.serial_busy), 0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      chk_en = 1'b1;

      // RAW on a load destination, freed by ret_clr
      drive(1'b1, OP_LOAD, 5'd1, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      #1 cmp("raw_load_ready", int'(bus.id_ready), 1);
      step();
      drive(1'b1, OP_ALU, 5'd5, 5'd1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      #1 cmp("raw_hazard", int'(bus.hazard), 1);
      cmp("raw_held", int'(bus.id_ready), 0);
      step();
      drive(1'b1, OP_ALU, 5'd5, 5'd1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5);
      #1 cmp("raw_clr_cycle", int'(bus.id_ready), 0);
      step();
      drive(1'b1, OP_ALU, 5'd5, 5'd1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      #1 cmp("raw_after_clr", int'(bus.id_ready), 1);
      step();
      drain_all();

      // writes to x0 up to capacity
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, OP_ALU, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
         step();
      end
      drive(1'b1, OP_ALU, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      #1 cmp("cap_full_ready", int'(bus.id_ready), 0);
      cmp("cap_full_count", int'(bus.inflight), 3);
      step();
      drive(1'b1, OP_ALU, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
      #1 cmp("cap_retire_cycle", int'(bus.id_ready), 0);
      step();
      drive(1'b1, OP_ALU, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      #1 cmp("cap_after_retire", int'(bus.id_ready), 1);
      step();
      drain_all();

      // csrrw behind two ALU ops
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, OP_ALU, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
         step();
      end
      drive(1'b1, OP_CSRRW, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      #1 cmp("csr_blocked", int'(bus.id_ready), 0);
      step();
      drive(1'b1, OP_CSRRW, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      #1 cmp("csr_draining", int'(bus.serial_busy), 1);
      step();
      drive(1'b1, OP_CSRRW, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
      step();
      drive(1'b1, OP_CSRRW, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
      #1 cmp("csr_last_retire", int'(bus.id_ready), 0);
      step();
      drive(1'b1, OP_CSRRW, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      #1 cmp("csr_issue", int'(bus.id_ready), 1);
      step();
      drive(1'b1, OP_ALU, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      #1 cmp("csr_younger_held", int'(bus.id_ready), 0);
      step();
      drive(1'b1, OP_ALU, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9);
      #1 cmp("csr_retire_cycle", int'(bus.id_ready), 0);
      step();
      drive(1'b1, OP_ALU, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      #1 cmp("csr_younger_go", int'(bus.id_ready), 1);
      cmp("csr_idle", int'(bus.serial_busy), 0);
      step();
      drain_all();

      // fence.i squashed while draining, then re-presented
      drive(1'b1, OP_ALU, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      step();
      drive(1'b1, OP_FENCEI, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      step();
      drive(1'b1, OP_FENCEI, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
      #1 cmp("fence_flush_ready", int'(bus.id_ready), 0);
      step();
      drive(1'b0, OP_NOP, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      #1 cmp("fence_flushed_idle", int'(bus.serial_busy), 0);
      step();
      drive(1'b1, OP_FENCEI, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      step();
      drive(1'b1, OP_FENCEI, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
      #1 cmp("fence_redrain", int'(bus.serial_busy), 1);
      step();
      drive(1'b1, OP_FENCEI, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      step();
      drain_all();

      // same-cycle set and clear of x7: set wins
      drive(1'b1, OP_ALU, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      step();
      drive(1'b1, OP_ALU, 5'd0, 5'd0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7);
      step();
      drive(1'b1, OP_ALU, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      #1 cmp("setwins_hazard", int'(bus.hazard), 1);
      step();
      drain_all();

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         v  = ($urandom_range(0, 3) != 0);
         op = ($urandom_range(0, 3) == 0) ? op_t'(5'($urandom_range(7, 21)))
                                          : op_t'(5'($urandom_range(0, 6)));
         r1 = 5'($urandom_range(0, 7));
         r2 = 5'($urandom_range(0, 7));
         we = ($urandom_range(0, 1) == 1);
         wa = 5'($urandom_range(0, 7));
         st = ($urandom_range(0, 4) == 0);
         fl = ($urandom_range(0, 19) == 0);
         rv = (q.size() > 0) && ($urandom_range(0, 9) < 4);
         rc = 1'b0;
         rw = 5'($urandom_range(0, 31));
         if (rv) begin
            e  = q[0];
            rc = e.we && (e.wa != 5'd0);
            rw = e.wa;
         end
         drive(v, op, r1, r2, we, wa, st, fl, rv, rc, rw);
         step();
      end
      drain_all();

      // retire with nothing in flight
      drive(1'b0, OP_NOP, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0);
      step();
      drive(1'b0, OP_NOP, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      #1 cmp("underflow_err", int'(bus.sb_err), 1);
      cmp("underflow_count", int'(bus.inflight), 0);
      step();

      // reset while a serial op waits to retire
      drive(1'b1, OP_CSRRW, 5'd0, 5'd0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      step();
      drive(1'b1, OP_ALU, 5'd8, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      #1 cmp("pre_rst_busy", int'(bus.serial_busy), 1);
      chk_en = 1'b0;
      rst_n = 1'b0;
      #1;
      cmp("async_rst_ready", int'(bus.id_ready), 0);
      cmp("async_rst_hazard", int'(bus.hazard), 0);
      cmp("async_rst_busy", int'(bus.serial_busy), 0);
      cmp("async_rst_count", int'(bus.inflight), 0);
      cmp("async_rst_err", int'(bus.sb_err), 0);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk_en = 1'b1;
      drive(1'b1, OP_ALU, 5'd8, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      #1 cmp("post_rst_no_hazard", int'(bus.hazard), 0);
      cmp("post_rst_ready", int'(bus.id_ready), 1);
      step();
      drain_all();
      drive(1'b0, OP_NOP, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      step();
      chk_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
